cacheline_burst_responder: RTL and testbench
============================================

// Module: cacheline_burst_responder
// PURPOSE
//  Memory-side responder for the cache pmem_read/pmem_write/pmem_resp handshake.
//  Accepts one 256-bit line read or write from a cache controller (D-cache or I-cache via arbiter)
//  and runs it as a 4-beat x 64-bit burst to main memory; pulses pmem_resp on completion.
//  Sits between the cache pmem_* ports and the top-level burst memory interface.
// PARAMETERS
//  LINE_W    256  cache line width (bits)
//  BEAT_W    64   memory burst beat width; BEATS = LINE_W/BEAT_W = 4
//  ADDR_W    32   address width; line offset = $clog2(LINE_W/8) = 5 bits
//  TIMEOUT   1023 watchdog limit in cycles (used only with CLA_TIMEOUT_EN)
// PORTS
//  clk            in   1       clock, all state on posedge
//  rst            in   1       asynchronous, active-low reset (asserted when 0)
//  pmem_address   in   ADDR_W  cache line address; sampled at accept
//  pmem_read      in   1       cache read request, held until pmem_resp
//  pmem_write     in   1       cache write request, held until pmem_resp
//  pmem_wdata     in   LINE_W  line to write; sampled at accept
//  pmem_rdata     out  LINE_W  read line; valid in pmem_resp cycle, held until next read completes
//  pmem_resp      out  1       one-cycle completion pulse
//  burst_address  out  ADDR_W  {pmem_address[ADDR_W-1:5], 5'b0}, stable for whole burst
//  burst_read     out  1       memory read request
//  burst_write    out  1       memory write request
//  burst_wdata    out  BEAT_W  current write beat
//  burst_rdata    in   BEAT_W  read beat, valid when burst_resp=1
//  burst_resp     in   1       memory beat strobe; one beat per cycle it is high
//  timeout_err    out  1       sticky watchdog error (0 when macro absent)
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, beat cnt 0, all outputs 0 incl. pmem_rdata, burst_address.
//  - FSM: IDLE -> RD_BURST | WR_BURST -> DONE -> IDLE.
//  - IDLE: pmem_write=1 -> latch addr+wdata, go WR_BURST; else pmem_read=1 -> latch addr, go RD_BURST.
//    Both high: write wins. No request: stay.
//  - RD_BURST: burst_read=1. Each cycle burst_resp=1: store burst_rdata at beat[cnt*64 +: 64], cnt++.
//    Beat 3 accepted -> DONE. burst_resp=0 stalls (cnt holds).
//  - WR_BURST: burst_write=1, burst_wdata = line[cnt*64 +: 64] (beat 0 = bits 63:0). Advance on burst_resp.
//    Beat 3 accepted -> DONE.
//  - burst_read/burst_write registered; rise the cycle after accept, fall the cycle after last beat.
//  - DONE: pmem_resp=1 for exactly one cycle; pmem_rdata updated (read only); then IDLE.
//    Request seen in the following IDLE cycle is new (cache drops request after resp).
//  - Latency: accept at cycle 0; beats at cycles 1..4 with no stalls -> pmem_resp at cycle 5.
//    Each stall cycle adds 1.
//  - Requests changing mid-burst are ignored; the latched addr/data are used.
//  - burst_resp in IDLE/DONE is ignored. cnt wraps 3 -> 0 only at burst end.
//  - Reset asserted mid-burst aborts: outputs 0 next edge-independent; no pmem_resp issued.
// CONFIGURATION
//  CLA_TIMEOUT_EN defined: a watchdog counts cycles spent in RD_BURST/WR_BURST without burst_resp.
//    Reaching TIMEOUT sets timeout_err (sticky until reset), forces DONE, and pulses pmem_resp.
//    Read data for missing beats = 0.
//  Absent: no counter; timeout_err tied 0; bursts wait indefinitely.
// STRUCTURE
//  - New package cacheline_pkg: cla_state_t enum {IDLE, RD_BURST, WR_BURST, DONE},
//    localparams CLA_BEATS=4, CLA_OFFSET_W=5.
//  - One sub-module: cla_watchdog (counter + compare, clear on beat/burst end), instantiated only
//    under CLA_TIMEOUT_EN.
// TESTING
//  1. Read 0x0000_1234, burst_rdata beats 0x11..,0x22..,0x33..,0x44.. at cycles 1-4
//     -> burst_address=0x0000_1220; pmem_resp at cycle 5; pmem_rdata={0x44..,0x33..,0x22..,0x11..}.
//  2. Write line 0xDDDD..CCCC..BBBB..AAAA.. to 0x80 -> burst_wdata AAAA,BBBB,CCCC,DDDD in beat order;
//     burst_write falls after beat 3; pmem_resp once.
//  3. Read with burst_resp low for 3 cycles between beats 1 and 2 -> cnt holds; pmem_resp at cycle 8; data intact.
//  4. pmem_read and pmem_write both high in IDLE -> write burst performed; pmem_rdata unchanged.
//  5. rst=0 during beat 2 of a read -> outputs 0 immediately; after release, no pmem_resp; next read completes normally.
//  6. CLA_TIMEOUT_EN, TIMEOUT=8, memory silent -> timeout_err=1 and one pmem_resp ~9 cycles after accept;
//     without macro, no pmem_resp after 100 cycles.

Source files
------------

// File: rtl/cacheline_pkg.sv
// Shared types and constants for the cache-line burst responder.
package cacheline_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } cla_state_t;

    localparam int unsigned CLA_BEATS    = 4;
    localparam int unsigned CLA_OFFSET_W = 5;
    localparam int unsigned CLA_CNT_W    = $clog2(CLA_BEATS);

endpackage

// File: rtl/cacheline_burst_responder_if.sv
// Cache-side pmem handshake: master = cache controller, slave = burst responder.
interface cacheline_burst_responder_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
);
    logic [ADDR_W-1:0] pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/cla_watchdog.sv
// Burst watchdog: down-counter reloaded on every beat or when idle; expires
// after LIMIT consecutive beat-less cycles. Only built with CLA_TIMEOUT_EN.
module cla_watchdog #(
    parameter int unsigned LIMIT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic beat,
    output logic expire
);
    localparam int unsigned CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= RELOAD;
        end else if (!active || beat) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = active && !beat && (count == '0);
endmodule

// File: rtl/cacheline_burst_responder.sv
// Turns one 256-bit cache line request into a 4 x 64-bit memory burst.
// Optional CLA_TIMEOUT_EN adds a watchdog that aborts a silent burst.
//
// state    | meaning
// IDLE     | waiting for pmem_write (priority) or pmem_read
// RD_BURST | collecting read beats into the line buffer
// WR_BURST | presenting write beats from the latched line
// DONE     | pmem_resp high for this single cycle
module cacheline_burst_responder
    import cacheline_pkg::*;
#(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned BEAT_W = 64,
    parameter int unsigned ADDR_W = 32
`ifdef CLA_TIMEOUT_EN
    , parameter int unsigned TIMEOUT = 1023
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    cacheline_burst_responder_if.slave  pmem,
    output logic [ADDR_W-1:0]           burst_address,
    output logic                        burst_read,
    output logic                        burst_write,
    output logic [BEAT_W-1:0]           burst_wdata,
    input  logic [BEAT_W-1:0]           burst_rdata,
    input  logic                        burst_resp,
    output logic                        timeout_err
);
    localparam logic [CLA_CNT_W-1:0] LAST_BEAT = CLA_CNT_W'(CLA_BEATS - 1);

    cla_state_t           state;
    logic [CLA_CNT_W-1:0] cnt;
    logic [CLA_CNT_W-1:0] cnt_nxt;
    logic [LINE_W-1:0]    line_q;
    logic [LINE_W-1:0]    line_nxt;
    logic [LINE_W-1:0]    rdata_q;
    logic                 resp_q;
    logic                 wd_expire;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^pmem.pmem_address[CLA_OFFSET_W-1:0];
    assign pmem.pmem_rdata  = rdata_q;
    assign pmem.pmem_resp   = resp_q;
    assign cnt_nxt          = cnt + 1'b1;

    always_comb begin
        line_nxt = line_q;
        line_nxt[cnt*BEAT_W +: BEAT_W] = burst_rdata;
    end

`ifdef CLA_TIMEOUT_EN
    cla_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .active (state == RD_BURST || state == WR_BURST),
        .beat   (burst_resp),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_err <= 1'b0;
        end else if (wd_expire) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            line_q        <= '0;
            rdata_q       <= '0;
            resp_q        <= 1'b0;
            burst_address <= '0;
            burst_read    <= 1'b0;
            burst_write   <= 1'b0;
            burst_wdata   <= '0;
        end else begin
            resp_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pmem.pmem_write) begin
                        line_q        <= pmem.pmem_wdata;
                        burst_address <= {pmem.pmem_address[ADDR_W-1:CLA_OFFSET_W], {CLA_OFFSET_W{1'b0}}};
                        burst_wdata   <= pmem.pmem_wdata[BEAT_W-1:0];
                        burst_write   <= 1'b1;
                        state         <= WR_BURST;
                    end else if (pmem.pmem_read) begin
                        // cleared so beats never delivered (watchdog abort) read back as 0
                        line_q        <= '0;
                        burst_address <= {pmem.pmem_address[ADDR_W-1:CLA_OFFSET_W], {CLA_OFFSET_W{1'b0}}};
                        burst_read    <= 1'b1;
                        state         <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (burst_resp) begin
                        line_q <= line_nxt;
                        cnt    <= cnt_nxt;
                        if (cnt == LAST_BEAT) begin
                            rdata_q    <= line_nxt;
                            burst_read <= 1'b0;
                            resp_q     <= 1'b1;
                            state      <= DONE;
                        end
                    end else if (wd_expire) begin
                        rdata_q    <= line_q;
                        cnt        <= '0;
                        burst_read <= 1'b0;
                        resp_q     <= 1'b1;
                        state      <= DONE;
                    end
                end
                WR_BURST: begin
                    if (burst_resp) begin
                        cnt <= cnt_nxt;
                        if (cnt == LAST_BEAT) begin
                            burst_wdata <= '0;
                            burst_write <= 1'b0;
                            resp_q      <= 1'b1;
                            state       <= DONE;
                        end else begin
                            burst_wdata <= line_q[cnt_nxt*BEAT_W +: BEAT_W];
                        end
                    end else if (wd_expire) begin
                        cnt         <= '0;
                        burst_wdata <= '0;
                        burst_write <= 1'b0;
                        resp_q      <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cacheline_burst_responder.sv
// Directed bench for cacheline_burst_responder; acts as both cache and memory.
module tb_cacheline_burst_responder;
    logic        clk;
    logic        rst_n;
    logic [31:0] burst_address;
    logic        burst_read;
    logic        burst_write;
    logic [63:0] burst_wdata;
    logic [63:0] burst_rdata;
    logic        burst_resp;
    logic        timeout_err;

    int n_tests;
    int n_fail;

    cacheline_burst_responder_if #(.ADDR_W(32), .LINE_W(256)) pmem_if ();

`ifdef CLA_TIMEOUT_EN
    cacheline_burst_responder #(.TIMEOUT(8)) dut (
`else
    cacheline_burst_responder dut (
`endif
        .clk           (clk),
        .rst           (rst_n),
        .pmem          (pmem_if),
        .burst_address (burst_address),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drives one cache request and plays memory; stall_n idle cycles are
    // inserted once stall_at beats have been delivered.
    task automatic run_burst(input string tag, input bit is_wr, input bit both,
                             input logic [31:0] addr, input logic [255:0] line,
                             input int stall_at, input int stall_n, input int max_cyc,
                             input int exp_lat, input logic [255:0] exp_rdata);
        int cyc;
        int sent;
        int stalls;
        int lat;
        logic [31:0] exp_addr;
        exp_addr = {addr[31:5], 5'b0};
        @(negedge clk);
        pmem_if.pmem_address = addr;
        pmem_if.pmem_wdata   = line;
        pmem_if.pmem_write   = is_wr;
        pmem_if.pmem_read    = !is_wr || both;
        @(posedge clk);
        cyc = 0; sent = 0; stalls = 0; lat = -1;
        while (cyc < max_cyc) begin
            @(negedge clk);
            if (cyc == 0) begin
                check({tag, "_addr"}, burst_address, exp_addr);
                check({tag, "_req_rise"}, is_wr ? burst_write : burst_read, 1);
                check({tag, "_other_req"}, is_wr ? burst_read : burst_write, 0);
                pmem_if.pmem_address = addr ^ 32'h00FF_0000;
                pmem_if.pmem_wdata   = ~line;
            end
            if (pmem_if.pmem_resp) begin
                lat = cyc + 1;
                break;
            end
            if (sent >= 4 || (sent == stall_at && stalls < stall_n)) begin
                burst_resp  = 1'b0;
                burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                stalls++;
            end else begin
                burst_resp  = 1'b1;
                burst_rdata = line[sent*64 +: 64];
                if (is_wr) check($sformatf("%s_wdata%0d", tag, sent), burst_wdata, line[sent*64 +: 64]);
                sent++;
            end
            @(posedge clk);
            cyc++;
        end
        burst_resp = 1'b0;
        check({tag, "_latency"}, lat, exp_lat);
        if (lat >= 0) begin
            check({tag, "_req_fall"}, {burst_read, burst_write}, 2'b00);
            check({tag, "_addr_held"}, burst_address, exp_addr);
            check({tag, "_rdata"}, pmem_if.pmem_rdata, exp_rdata);
            pmem_if.pmem_read  = 1'b0;
            pmem_if.pmem_write = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check({tag, "_resp_one_cycle"}, pmem_if.pmem_resp, 0);
        end
    endtask

    logic [255:0] line_a;
    logic [255:0] line_w;
    logic [255:0] line_c;
    logic [255:0] line_r;
    int           resp_seen;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        burst_resp  = 1'b0;
        burst_rdata = '0;
        pmem_if.pmem_address = '0;
        pmem_if.pmem_read    = 1'b0;
        pmem_if.pmem_write   = 1'b0;
        pmem_if.pmem_wdata   = '0;
        line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        line_w = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        line_c = {64'h0F0E_0D0C_0B0A_0908, 64'h0706_0504_0302_0100,
                  64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
        line_r = {64'hCAFE_0003_0000_0003, 64'hCAFE_0002_0000_0002,
                  64'hCAFE_0001_0000_0001, 64'hCAFE_0000_0000_0000};

        repeat (2) @(negedge clk);
        check("rst_resp", pmem_if.pmem_resp, 0);
        check("rst_rdata", pmem_if.pmem_rdata, 0);
        check("rst_addr", burst_address, 0);
        check("rst_reqs", {burst_read, burst_write}, 2'b00);
        check("rst_wdata", burst_wdata, 0);
        check("rst_timeout", timeout_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_burst("rd1", 1'b0, 1'b0, 32'h0000_1234, line_a, 9, 0, 50, 5, line_a);
        run_burst("wr1", 1'b1, 1'b0, 32'h0000_0080, line_w, 9, 0, 50, 5, line_a);
        run_burst("rd_stall", 1'b0, 1'b0, 32'h0000_0FFF, line_c, 2, 3, 50, 8, line_c);

        // memory strobes while idle must not disturb anything
        for (int i = 0; i < 3; i++) begin
            burst_resp  = 1'b1;
            burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
            @(negedge clk);
            check("idle_resp_ignored", {pmem_if.pmem_resp, burst_read, burst_write}, 3'b000);
        end
        burst_resp = 1'b0;
        check("idle_rdata_kept", pmem_if.pmem_rdata, line_c);

        run_burst("both_wr", 1'b1, 1'b1, 32'hFFFF_FFE7, line_w, 9, 0, 50, 5, line_c);

        // reset during beat 2 of a read
        pmem_if.pmem_address = 32'h0000_0040;
        pmem_if.pmem_read    = 1'b1;
        @(posedge clk);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            burst_resp  = 1'b1;
            burst_rdata = line_r[b*64 +: 64];
            @(posedge clk);
        end
        @(negedge clk);
        burst_resp  = 1'b1;
        burst_rdata = line_r[2*64 +: 64];
        rst_n = 1'b0;
        #1;
        check("abort_reqs", {burst_read, burst_write}, 2'b00);
        check("abort_addr", burst_address, 0);
        check("abort_rdata", pmem_if.pmem_rdata, 0);
        check("abort_resp", pmem_if.pmem_resp, 0);
        burst_resp = 1'b0;
        pmem_if.pmem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        resp_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (pmem_if.pmem_resp) resp_seen++;
        end
        check("abort_no_resp", resp_seen, 0);
        run_burst("rd_after_rst", 1'b0, 1'b0, 32'h0000_0040, line_r, 9, 0, 50, 5, line_r);

        // memory silent for the whole burst
`ifdef CLA_TIMEOUT_EN
        run_burst("silent", 1'b0, 1'b0, 32'h0000_2000, line_a, 0, 1000, 100, 9, 256'h0);
        check("silent_timeout_err", timeout_err, 1);
`else
        run_burst("silent", 1'b0, 1'b0, 32'h0000_2000, line_a, 0, 1000, 100, -1, 256'h0);
        check("silent_timeout_err", timeout_err, 0);
        check("silent_still_busy", burst_read, 1);
`endif
        pmem_if.pmem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("final_timeout_cleared", timeout_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
